// File: rtl/func_gen_pkg.sv
// Constants and state encoding shared by the function generator and the
// receive-side wave period analyzer.
package func_gen_pkg;

    // Sample format: 8-bit unsigned, offset binary (mid-scale is "zero").
    localparam int DW_DEF   = 8;
    localparam int PW_DEF   = 16;
    localparam int MID_DEF  = 128;
    localparam int HYST_DEF = 8;

    // Analyzer measurement FSM.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meas_state_e;

endpackage

// File: rtl/wave_minmax_tracker.sv
// Running min/max accumulator for one waveform cycle. The next_* outputs
// already fold in the current sample so the owner can publish a result on
// the same edge that clears the accumulators.
module wave_minmax_tracker
    import func_gen_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          update,
    input  logic [DW-1:0] sample,
    output logic [DW-1:0] next_min,
    output logic [DW-1:0] next_max
);

    logic [DW-1:0] min_acc_r;
    logic [DW-1:0] max_acc_r;

    // Candidate extremes including the sample presented this cycle.
    always_comb begin
        next_min = min_acc_r;
        next_max = max_acc_r;
        if (sample < min_acc_r) begin
            next_min = sample;
        end else begin
            next_min = min_acc_r;
        end
        if (sample > max_acc_r) begin
            next_max = sample;
        end else begin
            next_max = max_acc_r;
        end
    end

    // Accumulators start empty (min at full scale, max at zero) after a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_acc_r <= {DW{1'b1}};
            max_acc_r <= {DW{1'b0}};
        end else if (clear) begin
            min_acc_r <= {DW{1'b1}};
            max_acc_r <= {DW{1'b0}};
        end else if (update) begin
            min_acc_r <= next_min;
            max_acc_r <= next_max;
        end else begin
            min_acc_r <= min_acc_r;
            max_acc_r <= max_acc_r;
        end
    end

endmodule

// File: rtl/wave_period_analyzer.sv
// Measures period, min, max and peak-to-peak of an unsigned sample stream
// using mid-scale rising crossings with a hysteresis band. A sample at or
// below MID-HYST arms the detector; an armed sample at or above MID+HYST is
// a crossing. The first crossing opens a cycle, each later one closes it.
module wave_period_analyzer
    import func_gen_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int PW   = PW_DEF,
    parameter int MID  = MID_DEF,
    parameter int HYST = HYST_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_valid,
    output logic [PW-1:0] period,
    output logic [DW-1:0] min_val,
    output logic [DW-1:0] max_val,
    output logic [DW-1:0] p2p,
    output logic          meas_valid,
    output logic          no_signal
);

    localparam logic [DW-1:0] ARM_LVL   = DW'(MID - HYST);
    localparam logic [DW-1:0] CROSS_LVL = DW'(MID + HYST);
    // Largest count before a cycle is abandoned; cnt never wraps.
    localparam logic [PW-1:0] CNT_LIMIT = {{(PW-1){1'b1}}, 1'b0};
    localparam logic [PW-1:0] CNT_ONE   = {{(PW-1){1'b0}}, 1'b1};

    meas_state_e   state_r;
    logic [PW-1:0] cnt_r;
    logic          armed_r;

    logic          arm_s;
    logic          cross_s;
    logic          timeout_s;
    logic          update_s;
    logic [DW-1:0] next_min_s;
    logic [DW-1:0] next_max_s;

    // Crossing, arming, timeout and accumulate qualifiers for this sample.
    always_comb begin
        arm_s     = 1'b0;
        cross_s   = 1'b0;
        timeout_s = 1'b0;
        update_s  = 1'b0;
        if (sample_valid) begin
            arm_s   = (sample_in <= ARM_LVL);
            cross_s = armed_r && (sample_in >= CROSS_LVL);
            if ((state_r == ST_MEASURE) && !cross_s) begin
                timeout_s = (cnt_r == CNT_LIMIT);
                update_s  = (cnt_r != CNT_LIMIT);
            end else begin
                timeout_s = 1'b0;
                update_s  = 1'b0;
            end
        end else begin
            arm_s     = 1'b0;
            cross_s   = 1'b0;
            timeout_s = 1'b0;
            update_s  = 1'b0;
        end
    end

    wave_minmax_tracker #(
        .DW(DW)
    ) u_minmax (
        .clk      (clk),
        .rst      (rst),
        .clear    (cross_s),
        .update   (update_s),
        .sample   (sample_in),
        .next_min (next_min_s),
        .next_max (next_max_s)
    );

    // Hysteresis arm flag: a crossing or a timeout consumes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_r <= 1'b0;
        end else if (timeout_s || cross_s) begin
            armed_r <= 1'b0;
        end else if (arm_s) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= armed_r;
        end
    end

    // Measurement FSM with registered result outputs and one-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {PW{1'b0}};
            period     <= {PW{1'b0}};
            min_val    <= {DW{1'b0}};
            max_val    <= {DW{1'b0}};
            p2p        <= {DW{1'b0}};
            meas_valid <= 1'b0;
            no_signal  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cross_s) begin
                        state_r <= ST_MEASURE;
                        cnt_r   <= {PW{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MEASURE: begin
                    if (cross_s) begin
                        period     <= cnt_r + CNT_ONE;
                        min_val    <= next_min_s;
                        max_val    <= next_max_s;
                        p2p        <= next_max_s - next_min_s;
                        meas_valid <= 1'b1;
                        no_signal  <= 1'b0;
                        cnt_r      <= {PW{1'b0}};
                    end else if (timeout_s) begin
                        no_signal <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else if (update_s) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {PW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_period_analyzer.sv
// Scoreboard bench for wave_period_analyzer. Stimulus phases push their
// hand-computed measurements; a monitor pops one per meas_valid strobe.
// A 9-bit period counter keeps the timeout (510 counted samples) short
// while still holding the 256-sample sawtooth period.
module tb_wave_period_analyzer;

    localparam int PW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    sample_in;
    logic          sample_valid;
    logic [PW-1:0] period;
    logic [7:0]    min_val;
    logic [7:0]    max_val;
    logic [7:0]    p2p;
    logic          meas_valid;
    logic          no_signal;

    typedef struct {
        int per;
        int mn;
        int mx;
        int pp;
        int gap;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   last_meas = 0;

    wave_period_analyzer #(
        .DW(8), .PW(PW), .MID(128), .HYST(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .period       (period),
        .min_val      (min_val),
        .max_val      (max_val),
        .p2p          (p2p),
        .meas_valid   (meas_valid),
        .no_signal    (no_signal)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure strobe spacing.
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: compare every presented measurement against the scoreboard.
    always @(negedge clk) begin
        if (!rst && meas_valid) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_meas: got period %0d, expected no measurement", period);
            end else begin
                e = sb.pop_front();
                check("period", int'(period), e.per);
                check("min_val", int'(min_val), e.mn);
                check("max_val", int'(max_val), e.mx);
                check("p2p", int'(p2p), e.pp);
                check("meas_no_signal", int'(no_signal), 0);
                if (e.gap != 0) check("meas_gap", cyc - last_meas, e.gap);
            end
            last_meas = cyc;
        end
    end

    task automatic step(input logic [7:0] s, input logic v);
        sample_in    = s;
        sample_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int p, input int mn, input int mx, input int pp, input int gap);
        exp_t x;
        x.per = p; x.mn = mn; x.mx = mx; x.pp = pp; x.gap = gap;
        sb.push_back(x);
    endtask

    task automatic ramps(input int n);
        for (int r = 0; r < n; r++)
            for (int i = 0; i < 256; i++) step(8'(i), 1'b1);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        sample_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check({tag, "_period"}, int'(period), 0);
        check({tag, "_max"}, int'(max_val), 0);
        check({tag, "_p2p"}, int'(p2p), 0);
        check({tag, "_no_signal"}, int'(no_signal), 0);
        check({tag, "_meas_valid"}, int'(meas_valid), 0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the directed run is a few thousand cycles.
    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        sample_in    = 8'd0;
        sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_period", int'(period), 0);
        check("rst_min", int'(min_val), 0);
        check("rst_max", int'(max_val), 0);
        check("rst_p2p", int'(p2p), 0);
        check("rst_meas_valid", int'(meas_valid), 0);
        check("rst_no_signal", int'(no_signal), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Square wave: 8 crossings -> 7 measurements of period 2.
        push(2, 0, 255, 255, 0);
        for (int k = 0; k < 6; k++) push(2, 0, 255, 255, 2);
        for (int k = 0; k < 8; k++) begin
            step(8'd0, 1'b1);
            step(8'd255, 1'b1);
        end
        step(8'd0, 1'b0);
        step(8'd0, 1'b0);
        check("sq_pending", sb.size(), 0);
        check("sq_hold_period", int'(period), 2);
        async_reset("rst_mid");

        // Sawtooth: 4 crossings -> 3 measurements of period 256.
        push(256, 0, 255, 255, 0);
        push(256, 0, 255, 255, 256);
        push(256, 0, 255, 255, 256);
        ramps(4);
        check("saw_pending", sb.size(), 0);
        async_reset("rst_saw");

        // Triangle, valid every other clock; invalid cycles carry inverted junk.
        push(126, 0, 252, 252, 0);
        push(126, 0, 252, 252, 252);
        push(126, 0, 252, 252, 252);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) begin
                step(8'(4 * i), 1'b1);
                step(8'(255 - 4 * i), 1'b0);
            end
            for (int i = 62; i > 0; i--) begin
                step(8'(4 * i), 1'b1);
                step(8'(255 - 4 * i), 1'b0);
            end
        end
        check("tri_pending", sb.size(), 0);
        async_reset("rst_tri");

        // One square measurement, then noisy midline until timeout.
        push(2, 0, 255, 255, 0);
        step(8'd0, 1'b1);
        step(8'd255, 1'b1);
        step(8'd0, 1'b1);
        step(8'd255, 1'b1);
        step(8'd0, 1'b0);
        step(8'd0, 1'b0);
        check("pre_noise_pending", sb.size(), 0);
        for (int k = 0; k < 510; k++) step((k % 2 == 0) ? 8'd125 : 8'd131, 1'b1);
        check("ns_before_timeout", int'(no_signal), 0);
        step(8'd125, 1'b1);
        check("ns_at_timeout", int'(no_signal), 1);
        for (int k = 0; k < 40; k++) step((k % 2 == 0) ? 8'd131 : 8'd125, 1'b1);
        check("hold_period", int'(period), 2);
        check("hold_min", int'(min_val), 0);
        check("hold_max", int'(max_val), 255);
        check("hold_p2p", int'(p2p), 255);
        check("ns_sticky", int'(no_signal), 1);

        // Recovery: first crossing only restarts; second one clears no_signal.
        push(256, 0, 255, 255, 0);
        for (int i = 0; i <= 136; i++) step(8'(i), 1'b1);
        check("ns_after_first_x", int'(no_signal), 1);
        check("mv_after_first_x", int'(meas_valid), 0);
        for (int i = 137; i < 256; i++) step(8'(i), 1'b1);
        ramps(1);
        check("ns_recovered", int'(no_signal), 0);
        check("final_pending", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
